// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Produces the single-cycle step strobe for the debug/dummy core.
//   In single mode every debounced press of the board button gives one step.
//   In run mode a prescaler issues free-running steps at a selectable rate.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before btn_level follows the button (>=1)
//   RUN_PERIOD       step period in cycles at rate_sel=0 (>=1)
//
// Ports
//   clk        system clock, all logic on posedge
//   aresetn    asynchronous active-low reset
//   btn_raw    raw step button (asynchronous, bouncy)
//   run_sw     raw mode switch (asynchronous): 0=single, 1=run
//   rate_sel   run-mode rate select; period = RUN_PERIOD >> (2*rate_sel), min 1
//   halt       1 = suppress step output and freeze the run prescaler
//   step       registered one-cycle step strobe
//   running    registered, 1 while the FSM is in RUN
//   btn_level  registered debounced button level
module step_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RUN_PERIOD      = 50_000_000
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       btn_raw,
    input  logic       run_sw,
    input  logic [1:0] rate_sel,
    input  logic       halt,
    output logic       step,
    output logic       running,
    output logic       btn_level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(RUN_PERIOD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        SINGLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          btn_s1;
    logic          btn_s2;
    logic          run_s1;
    logic          run_s2;

    logic [CW-1:0] cnt;
    logic          btn_level_q;
    logic          press;

    logic [31:0]   period_full;
    logic [PW-1:0] period_m1;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_d;
    logic          run_due;
    logic          step_d;

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            run_s1 <= run_sw;
            run_s2 <= run_s1;
        end
    end

    // Debounce: the level only changes after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any return to the current level restarts it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
            if (btn_s2 == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_level <= btn_s2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = btn_level & ~btn_level_q;

    // Period select; a shift that underflows to zero is clamped to one cycle.
    assign period_full = RUN_PERIOD >> {rate_sel, 1'b0};
    assign period_m1   = (period_full == 32'd0) ? '0 : PW'(period_full - 32'd1);

    // '>=' rather than '==' so that lowering the rate_sel period below the
    // current count wraps immediately and issues a step instead of running
    // the counter all the way round.
    assign run_due = (pcnt >= period_m1);

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt;
        step_d  = 1'b0;
        case (state_q)
            SINGLE: begin
                step_d = press & ~halt;
                pcnt_d = '0;
                if (run_s2) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                step_d = run_due & ~halt;
                if (!halt) begin
                    pcnt_d = run_due ? '0 : pcnt + PW'(1);
                end
                if (!run_s2) begin
                    state_d = SINGLE;
                    pcnt_d  = '0;
                end
            end
            default: begin
                state_d = SINGLE;
                pcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= SINGLE;
            pcnt    <= '0;
            step    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt    <= pcnt_d;
            step    <= step_d;
            running <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen
//   Bench for step_pulse_gen with DEBOUNCE_CYCLES=4, RUN_PERIOD=16.
//   Expected step edges are pushed to a queue when stimulus is applied and
//   consumed by a negedge monitor whenever step is seen high.
module tb_step_pulse_gen;

    localparam int unsigned D = 4;
    localparam int unsigned P = 16;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       btn_raw;
    logic       run_sw;
    logic [1:0] rate_sel;
    logic       halt;
    logic       step;
    logic       running;
    logic       btn_level;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int exp_q[$];

    typedef struct {
        logic [1:0] rate;
        int         period;
        int         nsteps;
    } rate_vec_t;

    rate_vec_t vecs[4];

    step_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .RUN_PERIOD     (P)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .btn_raw  (btn_raw),
        .run_sw   (run_sw),
        .rate_sel (rate_sel),
        .halt     (halt),
        .step     (step),
        .running  (running),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Every step pulse must match the next scheduled edge number.
    always @(negedge clk) begin
        if (step === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step got step after edge %0d expected none", edge_n);
            end else begin
                chk("step_time", edge_n, exp_q.pop_front());
            end
        end
    end

    task automatic goto_edge(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int e);
        goto_edge(e);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        chk({name, "_pending_steps"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic bounce [7];

    initial begin
        int k;
        int r;
        int t;
        int x;

        vecs[0] = '{rate: 2'd0, period: 16, nsteps: 3};
        vecs[1] = '{rate: 2'd1, period: 4,  nsteps: 4};
        vecs[2] = '{rate: 2'd2, period: 1,  nsteps: 5};
        vecs[3] = '{rate: 2'd3, period: 1,  nsteps: 5};
        bounce  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        aresetn  = 1'b0;
        btn_raw  = 1'b0;
        run_sw   = 1'b0;
        rate_sel = 2'd0;
        halt     = 1'b0;

        // Reset state
        sample_at(3);
        chk("rst_step", step, 0);
        chk("rst_running", running, 0);
        chk("rst_btn_level", btn_level, 0);
        goto_edge(5);
        aresetn = 1'b1;
        goto_edge(10);

        // 1: clean press, single step, release gives none
        k = edge_n + 1;
        btn_raw = 1'b1;
        exp_q.push_back(k + D + 2);
        sample_at(k + D);
        chk("press_level_before", btn_level, 0);
        sample_at(k + D + 1);
        chk("press_level_after", btn_level, 1);
        goto_edge(k + 19);
        btn_raw = 1'b0;
        sample_at(k + 40);
        chk("release_level", btn_level, 0);
        drain("clean_press");

        // 2: bounce never reaches the debounce threshold
        for (int i = 0; i < 7; i++) begin
            btn_raw = bounce[i];
            goto_edge(edge_n + 1);
        end
        btn_raw = 1'b0;
        sample_at(edge_n + 8);
        chk("bounce_level", btn_level, 0);
        goto_edge(edge_n + 1);
        k = edge_n + 1;
        btn_raw = 1'b1;
        exp_q.push_back(k + D + 2);
        goto_edge(k + 7);
        btn_raw = 1'b0;
        goto_edge(k + 25);
        drain("bounce_then_hold");

        // 2b: press edge while halted is dropped
        halt = 1'b1;
        k = edge_n + 1;
        btn_raw = 1'b1;
        sample_at(k + 9);
        chk("halt_press_level", btn_level, 1);
        goto_edge(k + 10);
        btn_raw = 1'b0;
        goto_edge(k + 25);
        halt = 1'b0;
        goto_edge(k + 30);
        drain("halt_press");

        // 3: run rates from the vector table
        for (int v = 0; v < 4; v++) begin
            rate_sel = vecs[v].rate;
            run_sw   = 1'b1;
            r = edge_n + 3;
            for (int i = 1; i <= vecs[v].nsteps; i++)
                exp_q.push_back(r + vecs[v].period * i);
            t = r + vecs[v].period * vecs[v].nsteps;
            sample_at(r - 1);
            chk("run_rise_before", running, 0);
            sample_at(r);
            chk("run_rise_after", running, 1);
            goto_edge(t - 3);
            run_sw = 1'b0;
            sample_at(t + 2);
            chk("run_fall", running, 0);
            goto_edge(t + 10);
            drain("run_rate");
        end

        // 3b: rate change mid-run wraps immediately
        rate_sel = 2'd0;
        run_sw   = 1'b1;
        r = edge_n + 3;
        goto_edge(r + 10);
        rate_sel = 2'd1;
        exp_q.push_back(r + 11);
        exp_q.push_back(r + 15);
        exp_q.push_back(r + 19);
        goto_edge(r + 16);
        run_sw = 1'b0;
        goto_edge(r + 30);
        drain("rate_change");
        rate_sel = 2'd0;

        // 4: halt freezes prescaler at 5 for 10 cycles
        run_sw = 1'b1;
        r = edge_n + 3;
        goto_edge(r + 5);
        halt = 1'b1;
        goto_edge(r + 15);
        halt = 1'b0;
        exp_q.push_back(r + 26);
        exp_q.push_back(r + 42);
        goto_edge(r + 39);
        run_sw = 1'b0;
        goto_edge(r + 55);
        drain("halt_run");

        // 5: press during RUN, drop to SINGLE while held, then new press
        run_sw = 1'b1;
        r = edge_n + 3;
        goto_edge(r + 1);
        btn_raw = 1'b1;
        goto_edge(r + 8);
        run_sw = 1'b0;
        sample_at(r + 20);
        chk("mode_held_running", running, 0);
        chk("mode_held_level", btn_level, 1);
        goto_edge(r + 21);
        btn_raw = 1'b0;
        goto_edge(r + 36);
        k = edge_n + 1;
        btn_raw = 1'b1;
        exp_q.push_back(k + D + 2);
        goto_edge(k + 10);
        btn_raw = 1'b0;
        goto_edge(k + 25);
        drain("mode_switch");

        // 6: async reset mid-run while step is high
        rate_sel = 2'd2;
        run_sw   = 1'b1;
        r = edge_n + 3;
        exp_q.push_back(r + 1);
        exp_q.push_back(r + 2);
        sample_at(r + 2);
        chk("pre_reset_step", step, 1);
        #1;
        aresetn = 1'b0;
        halt    = 1'b1;
        #1;
        chk("async_rst_step", step, 0);
        chk("async_rst_running", running, 0);
        goto_edge(edge_n + 3);
        aresetn = 1'b1;
        x = edge_n;
        sample_at(x + 2);
        chk("rerun_before", running, 0);
        sample_at(x + 3);
        chk("rerun_after", running, 1);
        goto_edge(x + 4);
        run_sw = 1'b0;
        sample_at(x + 10);
        chk("rerun_off", running, 0);
        halt = 1'b0;
        goto_edge(x + 14);
        drain("async_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
